// File: rtl/wisc_pkg.sv
// Shared WISC ISA encodings, control-word layout and decode helper for the
// pipelined control path.
package wisc_pkg;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_XOR    = 4'h2;
  localparam logic [3:0] OP_RED    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LLB    = 4'hA;
  localparam logic [3:0] OP_LHB    = 4'hB;
  localparam logic [3:0] OP_B      = 4'hC;
  localparam logic [3:0] OP_BR     = 4'hD;
  localparam logic [3:0] OP_PCS    = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  localparam logic [2:0] CCC_NE  = 3'd0;
  localparam logic [2:0] CCC_EQ  = 3'd1;
  localparam logic [2:0] CCC_GT  = 3'd2;
  localparam logic [2:0] CCC_LT  = 3'd3;
  localparam logic [2:0] CCC_GE  = 3'd4;
  localparam logic [2:0] CCC_LE  = 3'd5;
  localparam logic [2:0] CCC_OVF = 3'd6;
  localparam logic [2:0] CCC_UNC = 3'd7;

  localparam logic [2:0] ALU_ADD    = 3'd0;
  localparam logic [2:0] ALU_SUB    = 3'd1;
  localparam logic [2:0] ALU_XOR    = 3'd2;
  localparam logic [2:0] ALU_RED    = 3'd3;
  localparam logic [2:0] ALU_SLL    = 3'd4;
  localparam logic [2:0] ALU_SRA    = 3'd5;
  localparam logic [2:0] ALU_ROR    = 3'd6;
  localparam logic [2:0] ALU_PADDSB = 3'd7;

  // Flag masks are {N,Z,V}
  localparam logic [2:0] FM_NZV  = 3'b111;
  localparam logic [2:0] FM_Z    = 3'b010;
  localparam logic [2:0] FM_NONE = 3'b000;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_t;

  typedef struct packed {
    logic       regwrite;
    logic       memwrite;
    logic       memtoreg;
    logic       alusrc;
    logic       extsrc;
    logic       regsrc;
    logic       bytesel;
    logic       loadbyte;
    logic       pcs;
    logic [2:0] aluop;
    logic [2:0] flag_mask;
  } ctl_t;

  // ALU opcodes 0..7 map straight onto aluop; everything unused stays 0.
  function automatic ctl_t decode(input logic [3:0] op);
    ctl_t c;
    c = '0;
    if (!op[3]) begin
      c.regwrite = 1'b1;
      c.aluop    = op[2:0];
    end
    case (op)
      OP_ADD, OP_SUB:         c.flag_mask = FM_NZV;
      OP_XOR:                 c.flag_mask = FM_Z;
      OP_SLL, OP_SRA, OP_ROR: begin
        c.flag_mask = FM_Z;
        c.alusrc    = 1'b1;
      end
      OP_LW: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
        c.alusrc   = 1'b1;
        c.extsrc   = 1'b1;
        c.aluop    = ALU_ADD;
      end
      OP_SW: begin
        c.memwrite = 1'b1;
        c.regsrc   = 1'b1;
        c.alusrc   = 1'b1;
        c.extsrc   = 1'b1;
        c.aluop    = ALU_ADD;
      end
      OP_LLB: begin
        c.regwrite = 1'b1;
        c.loadbyte = 1'b1;
      end
      OP_LHB: begin
        c.regwrite = 1'b1;
        c.loadbyte = 1'b1;
        c.bytesel  = 1'b1;
      end
      OP_PCS: begin
        c.regwrite = 1'b1;
        c.pcs      = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational CCC condition evaluator over {N,Z,V}; shared by ID and any
// later EX-stage branch resolver.
module branch_cond_eval
  import wisc_pkg::*;
(
  input  logic [2:0] i_ccc,
  input  logic [2:0] i_nzv,
  output logic       o_cond
);

  logic w_n, w_z, w_v;
  logic [7:0] w_tbl;

  assign w_n = i_nzv[2];
  assign w_z = i_nzv[1];
  assign w_v = i_nzv[0];

  // One entry per CCC code, indexed directly by the code
  assign w_tbl[CCC_NE]  = ~w_z;
  assign w_tbl[CCC_EQ]  = w_z;
  assign w_tbl[CCC_GT]  = ~w_z & ~w_n;
  assign w_tbl[CCC_LT]  = w_n;
  assign w_tbl[CCC_GE]  = w_z | (~w_n & ~w_z);
  assign w_tbl[CCC_LE]  = w_n | w_z;
  assign w_tbl[CCC_OVF] = w_v;
  assign w_tbl[CCC_UNC] = 1'b1;

  assign o_cond = w_tbl[i_ccc];

endmodule

// File: rtl/id_ctrl_pipe.sv
// ID-stage controller: decode into the ID/EX control register, NZV flag
// ownership, ID branch resolution with one-cycle flush, and HLT drain FSM.
module id_ctrl_pipe
  import wisc_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4,
  parameter int FLAG_BYPASS  = 1,
  parameter int ALUOP_W      = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [15:0]        id_instr,
  input  logic               id_stall,
  input  logic [2:0]         ex_flag_we,
  input  logic [2:0]         ex_nzv,
  output logic               ctl_valid,
  output logic               ctl_regwrite,
  output logic               ctl_memwrite,
  output logic               ctl_memtoreg,
  output logic               ctl_alusrc,
  output logic               ctl_extsrc,
  output logic               ctl_regsrc,
  output logic               ctl_bytesel,
  output logic               ctl_loadbyte,
  output logic               ctl_pcs,
  output logic [ALUOP_W-1:0] ctl_aluop,
  output logic [2:0]         ctl_flag_mask,
  output logic               br_taken,
  output logic               br_reg,
  output logic               flush,
  output logic               pc_write,
  output logic               halted,
  output logic [2:0]         flags
);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_halted;
  logic       r_flush;
  logic [2:0] r_flags;
  ctl_t       r_ctl;
  logic       r_ctl_valid;

  logic [3:0] w_op;
  logic [2:0] w_ccc;
  logic       w_eff_v, w_issue, w_cond, w_hlt, w_load;
  logic [2:0] w_wr_flags, w_bflags;
  ctl_t       w_dec;
  logic       w_unused;

  assign w_op     = id_instr[15:12];
  assign w_ccc    = id_instr[11:9];
  assign w_unused = ^id_instr[8:0];

  assign w_eff_v = id_valid & ~r_flush & (r_state == ST_RUN);
  assign w_issue = w_eff_v & ~id_stall;

  // Flags as they will be after this cycle's EX write
  assign w_wr_flags = (ex_flag_we & ex_nzv) | (~ex_flag_we & r_flags);
  assign w_bflags   = (FLAG_BYPASS != 0) ? w_wr_flags : r_flags;

  branch_cond_eval u_cond (
    .i_ccc  (w_ccc),
    .i_nzv  (w_bflags),
    .o_cond (w_cond)
  );

  assign br_taken = w_issue & (w_op == OP_B)  & w_cond;
  assign br_reg   = w_issue & (w_op == OP_BR) & w_cond;
  assign w_hlt    = w_issue & (w_op == OP_HLT);
  assign pc_write = (r_state == ST_RUN) & ~id_stall & ~(w_eff_v & (w_op == OP_HLT));

  // Taken branches and HLT go down the pipe as bubbles
  assign w_dec  = decode(w_op);
  assign w_load = w_issue & ~br_taken & ~br_reg & (w_op != OP_HLT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctl       <= '0;
      r_ctl_valid <= 1'b0;
      r_flush     <= 1'b0;
      r_flags     <= 3'b000;
    end else begin
      r_ctl       <= w_load ? w_dec : '0;
      r_ctl_valid <= w_load;
      r_flush     <= br_taken | br_reg;
      r_flags     <= w_wr_flags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_RUN;
      r_cnt    <= 4'd0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: if (w_hlt) begin
          r_state <= ST_DRAIN;
          r_cnt   <= 4'(DRAIN_CYCLES - 1);
        end
        ST_DRAIN: if (r_cnt == 4'd0) begin
          r_state  <= ST_HALTED;
          r_halted <= 1'b1;
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
        default: r_halted <= 1'b1;
      endcase
    end
  end

  assign ctl_valid     = r_ctl_valid;
  assign ctl_regwrite  = r_ctl.regwrite;
  assign ctl_memwrite  = r_ctl.memwrite;
  assign ctl_memtoreg  = r_ctl.memtoreg;
  assign ctl_alusrc    = r_ctl.alusrc;
  assign ctl_extsrc    = r_ctl.extsrc;
  assign ctl_regsrc    = r_ctl.regsrc;
  assign ctl_bytesel   = r_ctl.bytesel;
  assign ctl_loadbyte  = r_ctl.loadbyte;
  assign ctl_pcs       = r_ctl.pcs;
  assign ctl_aluop     = ALUOP_W'(r_ctl.aluop);
  assign ctl_flag_mask = r_ctl.flag_mask;
  assign flush         = r_flush;
  assign halted        = r_halted;
  assign flags         = r_flags;

endmodule

// File: tb/tb_id_ctrl_pipe.sv
// Self-checking bench for id_ctrl_pipe: decode table, hand sequences for
// flags/bypass/stall/halt, and a randomized run against a reference model.
module tb_id_ctrl_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic [15:0] id_instr = 16'h0;
  logic        id_stall = 1'b0;
  logic [2:0]  ex_flag_we = 3'b0;
  logic [2:0]  ex_nzv = 3'b0;

  logic a_valid, a_rw, a_mw, a_m2r, a_asrc, a_esrc, a_rsrc, a_bsel, a_lb, a_pcs;
  logic [2:0] a_aluop, a_mask, a_flags;
  logic a_brt, a_brr, a_flush, a_pcw, a_halted;
  logic b_valid, b_rw, b_mw, b_m2r, b_asrc, b_esrc, b_rsrc, b_bsel, b_lb, b_pcs;
  logic [2:0] b_aluop, b_mask, b_flags;
  logic b_brt, b_brr, b_flush, b_pcw, b_halted;

  always #5 clk = ~clk;

  id_ctrl_pipe #(.DRAIN_CYCLES(4), .FLAG_BYPASS(1), .ALUOP_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
    .id_stall(id_stall), .ex_flag_we(ex_flag_we), .ex_nzv(ex_nzv),
    .ctl_valid(a_valid), .ctl_regwrite(a_rw), .ctl_memwrite(a_mw),
    .ctl_memtoreg(a_m2r), .ctl_alusrc(a_asrc), .ctl_extsrc(a_esrc),
    .ctl_regsrc(a_rsrc), .ctl_bytesel(a_bsel), .ctl_loadbyte(a_lb),
    .ctl_pcs(a_pcs), .ctl_aluop(a_aluop), .ctl_flag_mask(a_mask),
    .br_taken(a_brt), .br_reg(a_brr), .flush(a_flush), .pc_write(a_pcw),
    .halted(a_halted), .flags(a_flags)
  );

  id_ctrl_pipe #(.DRAIN_CYCLES(4), .FLAG_BYPASS(0), .ALUOP_W(3)) dut0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
    .id_stall(id_stall), .ex_flag_we(ex_flag_we), .ex_nzv(ex_nzv),
    .ctl_valid(b_valid), .ctl_regwrite(b_rw), .ctl_memwrite(b_mw),
    .ctl_memtoreg(b_m2r), .ctl_alusrc(b_asrc), .ctl_extsrc(b_esrc),
    .ctl_regsrc(b_rsrc), .ctl_bytesel(b_bsel), .ctl_loadbyte(b_lb),
    .ctl_pcs(b_pcs), .ctl_aluop(b_aluop), .ctl_flag_mask(b_mask),
    .br_taken(b_brt), .br_reg(b_brr), .flush(b_flush), .pc_write(b_pcw),
    .halted(b_halted), .flags(b_flags)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {valid,regwrite,memwrite,memtoreg,alusrc,extsrc,regsrc,bytesel,loadbyte,pcs,aluop[2:0],mask[2:0]}
  function automatic logic [15:0] ctl_a();
    return {a_valid, a_rw, a_mw, a_m2r, a_asrc, a_esrc, a_rsrc, a_bsel, a_lb, a_pcs, a_aluop, a_mask};
  endfunction

  function automatic logic cond_ref(input logic [2:0] ccc, input logic [2:0] f);
    logic n, z, v;
    n = f[2]; z = f[1]; v = f[0];
    case (ccc)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || (!n && !z);
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [15:0] ctl_ref(input logic [3:0] op);
    logic [15:0] e;
    e = 16'h8000;
    if (op < 4'd8) begin
      e[14] = 1'b1;
      e[5:3] = op[2:0];
    end
    if (op inside {4'd0, 4'd1}) e[2:0] = 3'b111;
    if (op inside {4'd2, 4'd4, 4'd5, 4'd6}) e[2:0] = 3'b010;
    if (op inside {4'd4, 4'd5, 4'd6}) e[11] = 1'b1;
    case (op)
      4'h8: begin e[14] = 1; e[12] = 1; e[11] = 1; e[10] = 1; end
      4'h9: begin e[13] = 1; e[11] = 1; e[10] = 1; e[9] = 1; end
      4'hA: begin e[14] = 1; e[7] = 1; end
      4'hB: begin e[14] = 1; e[8] = 1; e[7] = 1; end
      4'hE: begin e[14] = 1; e[6] = 1; end
      default: ;
    endcase
    return e;
  endfunction

  typedef struct {
    logic [15:0] instr;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[15];

  initial begin
    logic [2:0]  m_flags, bf;
    logic        m_flush, v, s, eff, tk, tr;
    logic [3:0]  op;
    logic [15:0] ins, ectl;

    tbl[0]  = '{16'h0123, 16'hC007};
    tbl[1]  = '{16'h1456, 16'hC00F};
    tbl[2]  = '{16'h2456, 16'hC012};
    tbl[3]  = '{16'h3456, 16'hC018};
    tbl[4]  = '{16'h4452, 16'hC822};
    tbl[5]  = '{16'h5452, 16'hC82A};
    tbl[6]  = '{16'h6452, 16'hC832};
    tbl[7]  = '{16'h7456, 16'hC038};
    tbl[8]  = '{16'h8123, 16'hDC00};
    tbl[9]  = '{16'h9123, 16'hAE00};
    tbl[10] = '{16'hA1FF, 16'hC080};
    tbl[11] = '{16'hB1FF, 16'hC180};
    tbl[12] = '{16'hCC04, 16'h8000};
    tbl[13] = '{16'hDC40, 16'h8000};
    tbl[14] = '{16'hE200, 16'hC040};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl", 32'(ctl_a()), 32'h0);
    chk("rst_flush", 32'(a_flush), 32'h0);
    chk("rst_halted", 32'(a_halted), 32'h0);
    chk("rst_flags", 32'(a_flags), 32'h0);
    rst_n = 1'b1;

    // Decode table; flags are 000 so table branches are not taken
    for (int i = 0; i < 15; i++) begin
      id_valid = 1'b1;
      id_instr = tbl[i].instr;
      tick();
      chk($sformatf("dec_%0h", tbl[i].instr), 32'(ctl_a()), 32'(tbl[i].exp));
      chk("dec_flush", 32'(a_flush), 32'h0);
    end
    id_valid = 1'b0;
    tick();
    chk("bubble_ctl", 32'(ctl_a()), 32'h0);

    // Asynchronous reset mid-stream clears control word and flags
    id_valid = 1'b1; id_instr = 16'h0123; ex_flag_we = 3'b111; ex_nzv = 3'b101;
    tick();
    chk("pre_rst_valid", 32'(a_valid), 32'h1);
    chk("pre_rst_flags", 32'(a_flags), 32'h5);
    id_valid = 1'b0; ex_flag_we = 3'b000;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ctl", 32'(ctl_a()), 32'h0);
    chk("async_rst_flags", 32'(a_flags), 32'h0);
    tick();
    rst_n = 1'b1;

    // Flag masking
    ex_flag_we = 3'b111; ex_nzv = 3'b100;
    tick();
    chk("flags_100", 32'(a_flags), 32'h4);
    ex_flag_we = 3'b010; ex_nzv = 3'b010;
    tick();
    chk("flags_110", 32'(a_flags), 32'h6);
    ex_flag_we = 3'b000; ex_nzv = 3'b001;
    tick();
    chk("flags_hold", 32'(a_flags), 32'h6);

    // Bypass: Z written by EX in the same cycle as B EQ
    ex_flag_we = 3'b111; ex_nzv = 3'b000;
    tick();
    ex_flag_we = 3'b010; ex_nzv = 3'b010;
    id_valid = 1'b1; id_instr = 16'hC200;
    #1;
    chk("byp_br_taken", 32'(a_brt), 32'h1);
    chk("nobyp_br_taken", 32'(b_brt), 32'h0);
    tick();
    chk("byp_flush", 32'(a_flush), 32'h1);
    chk("nobyp_flush", 32'(b_flush), 32'h0);
    chk("byp_br_bubble", 32'(a_valid), 32'h0);
    chk("nobyp_br_issue", 32'(b_valid), 32'h1);
    ex_flag_we = 3'b000; id_instr = 16'h0123;
    #1;
    chk("flush_pcw", 32'(a_pcw), 32'h1);
    chk("flush_no_br", 32'(a_brt), 32'h0);
    tick();
    chk("flushed_slot", 32'(a_valid), 32'h0);
    chk("flush_one_cycle", 32'(a_flush), 32'h0);
    id_valid = 1'b0;
    tick();

    // CCC x NZV sweep for B and BR
    for (int c = 0; c < 8; c++) begin
      for (int n = 0; n < 8; n++) begin
        id_valid = 1'b0; ex_flag_we = 3'b111; ex_nzv = 3'(n);
        tick();
        ex_flag_we = 3'b000;
        id_valid = 1'b1; id_instr = {4'hC, 3'(c), 9'h0};
        #1;
        chk($sformatf("sw_b c%0d f%0d", c, n), 32'(a_brt), 32'(cond_ref(3'(c), 3'(n))));
        chk("sw_b_brreg", 32'(a_brr), 32'h0);
        id_instr = {4'hD, 3'(c), 9'h0};
        #1;
        chk($sformatf("sw_br c%0d f%0d", c, n), 32'(a_brr), 32'(cond_ref(3'(c), 3'(n))));
        chk($sformatf("sw_br0 c%0d f%0d", c, n), 32'(b_brr), 32'(cond_ref(3'(c), 3'(n))));
        chk("sw_br_brt", 32'(a_brt), 32'h0);
      end
    end
    id_valid = 1'b0;
    tick();

    // Load-use stall holds LW in ID
    id_valid = 1'b1; id_instr = 16'h8123; id_stall = 1'b1;
    #1;
    chk("stall_pcw", 32'(a_pcw), 32'h0);
    tick();
    chk("stall_bubble", 32'(ctl_a()), 32'h0);
    id_stall = 1'b0;
    #1;
    chk("unstall_pcw", 32'(a_pcw), 32'h1);
    tick();
    chk("lw_issue", 32'(ctl_a()), 32'hDC00);
    id_valid = 1'b0;
    tick();

    // Randomized run against the reference model (HLT excluded)
    ex_flag_we = 3'b111; ex_nzv = 3'b000;
    tick();
    m_flags = 3'b000; m_flush = 1'b0;
    for (int k = 0; k < 400; k++) begin
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 3) == 0);
      ins = 16'($urandom);
      if ($urandom_range(0, 2) == 0) ins[15:12] = 4'hC + 4'($urandom_range(0, 1));
      if (ins[15:12] == 4'hF) ins[15:12] = 4'h0;
      id_valid = v; id_stall = s; id_instr = ins;
      ex_flag_we = 3'($urandom); ex_nzv = 3'($urandom);
      op = ins[15:12];
      #1;
      eff = v && !m_flush;
      bf = (ex_flag_we & ex_nzv) | (~ex_flag_we & m_flags);
      tk = eff && !s && op == 4'hC && cond_ref(ins[11:9], bf);
      tr = eff && !s && op == 4'hD && cond_ref(ins[11:9], bf);
      chk("rnd_br_taken", 32'(a_brt), 32'(tk));
      chk("rnd_br_reg", 32'(a_brr), 32'(tr));
      chk("rnd_pcw", 32'(a_pcw), 32'(!s));
      ectl = (eff && !s && !tk && !tr) ? ctl_ref(op) : 16'h0;
      m_flags = bf;
      m_flush = tk || tr;
      tick();
      chk($sformatf("rnd_ctl %0h", ins), 32'(ctl_a()), 32'(ectl));
      chk("rnd_flags", 32'(a_flags), 32'(m_flags));
      chk("rnd_flush", 32'(a_flush), 32'(m_flush));
    end
    id_valid = 1'b0; id_stall = 1'b0; ex_flag_we = 3'b000;
    tick();
    tick();

    // HLT under stall is not accepted
    id_valid = 1'b1; id_instr = 16'hF000; id_stall = 1'b1;
    #1;
    chk("hlt_stall_pcw", 32'(a_pcw), 32'h0);
    tick();
    id_stall = 1'b0; id_valid = 1'b0;
    #1;
    chk("hlt_stall_run", 32'(a_pcw), 32'h1);
    tick();
    tick();
    chk("hlt_stall_halted", 32'(a_halted), 32'h0);
    chk("hlt_stall_pcw2", 32'(a_pcw), 32'h1);

    // HLT in the flushed slot is ignored
    id_valid = 1'b1; id_instr = 16'hCE00;
    #1;
    chk("unc_br", 32'(a_brt), 32'h1);
    tick();
    chk("unc_flush", 32'(a_flush), 32'h1);
    id_instr = 16'hF000;
    #1;
    chk("hlt_flushed_pcw", 32'(a_pcw), 32'h1);
    tick();
    id_valid = 1'b0;
    #1;
    chk("hlt_flushed_run", 32'(a_pcw), 32'h1);
    tick();

    // Reset during flush
    id_valid = 1'b1; id_instr = 16'hCE00;
    tick();
    chk("pre_rst_flush", 32'(a_flush), 32'h1);
    id_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_flush", 32'(a_flush), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Reset during drain returns to RUN
    id_valid = 1'b1; id_instr = 16'hF000;
    tick();
    id_valid = 1'b0;
    tick();
    chk("drain_pcw", 32'(a_pcw), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_drain_pcw", 32'(a_pcw), 32'h1);
    chk("rst_mid_drain_halt", 32'(a_halted), 32'h0);
    tick();
    rst_n = 1'b1;
    id_valid = 1'b1; id_instr = 16'h0123;
    tick();
    chk("post_drain_rst_issue", 32'(a_valid), 32'h1);
    id_valid = 1'b0;
    tick();

    // HLT accepted: halted after DRAIN_CYCLES further clocks
    id_valid = 1'b1; id_instr = 16'hF000;
    #1;
    chk("hlt_pcw", 32'(a_pcw), 32'h0);
    tick();
    chk("hlt_bubble", 32'(a_valid), 32'h0);
    chk("hlt_halted_e1", 32'(a_halted), 32'h0);
    id_instr = 16'h0123;
    for (int e = 2; e <= 5; e++) begin
      #1;
      chk($sformatf("drain_pcw_e%0d", e), 32'(a_pcw), 32'h0);
      tick();
      chk($sformatf("halted_e%0d", e), 32'(a_halted), 32'(e == 5));
      chk($sformatf("drain_ign_e%0d", e), 32'(a_valid), 32'h0);
    end
    for (int e = 0; e < 3; e++) begin
      tick();
      chk("halted_hold", 32'(a_halted), 32'h1);
      chk("halted_ign", 32'(a_valid), 32'h0);
      chk("halted_pcw", 32'(a_pcw), 32'h0);
    end
    id_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
